// File: rtl/filtered_ram_swap_control.sv
// Ping-pong store of filtered projections between the filter and the
// processing swap control; responder end of the fr_* angle handshake.
module filtered_ram_swap_control #(
  parameter int kAngleLength        = 8,
  parameter int kFilteredDataLength = 12,
  parameter int kSLength            = 10,
  parameter int kNoOfS              = 256,
  parameter int kNoOfAngles         = 180
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  frame_start,
  input  logic                                  hf_valid,
  input  logic        [kFilteredDataLength-1:0] hf_val,
  output logic                                  hf_ready,
  input  logic                                  fr_next_angle,
  output logic                                  fr_next_angle_ack,
  output logic        [kAngleLength-1:0]        fr_angle,
  output logic                                  fr_has_next_angle,
  input  logic signed [kSLength-1:0]            fr0_s_val,
  input  logic signed [kSLength-1:0]            fr1_s_val,
  output logic signed [kFilteredDataLength-1:0] fr0_val,
  output logic signed [kFilteredDataLength-1:0] fr1_val
);

  localparam int AW = $clog2(kNoOfS);
  localparam int CW = $clog2(kNoOfAngles + 1);
  localparam int FW = kFilteredDataLength;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FULL    = 2'd1;
  localparam logic [1:0] READING = 2'd2;

  localparam logic [AW-1:0] LAST = AW'(kNoOfS - 1);
  localparam logic [CW-1:0] NANG = CW'(kNoOfAngles);
  localparam logic signed [kSLength-1:0] HALF = kSLength'(kNoOfS / 2);

  logic [1:0][1:0]        bank_q, bank_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [AW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]          wr_angles_q, wr_angles_d;
  logic [CW-1:0]          rd_angles_q, rd_angles_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [kAngleLength-1:0] fr_angle_q, fr_angle_d;
  logic [FW-1:0]          rd0_q, rd0_d;
  logic [FW-1:0]          rd1_q, rd1_d;

  logic [FW-1:0] mem [2][kNoOfS];

  logic          wr_fire;
  logic          nb;
  logic          ack;
  logic          restart;
  logic          in0, in1;
  logic [AW-1:0] a0, a1;

  assign hf_ready = reset_n
                  & (bank_q[wr_bank_q] == EMPTY)
                  & (wr_angles_q < NANG);
  assign wr_fire  = hf_ready & hf_valid;

  assign fr_has_next_angle = rd_angles_q < NANG;
  assign nb  = rd_valid_q ? ~rd_bank_q : rd_bank_q;
  assign ack = fr_next_angle & fr_has_next_angle
             & (bank_q[nb] == FULL);
  assign fr_next_angle_ack = ack;

  assign restart = frame_start & ~fr_has_next_angle
                 & (wr_angles_q == NANG);

  // s is centred: adding kNoOfS/2 only flips the top address bit
  assign in0 = (fr0_s_val >= -HALF) && (fr0_s_val < HALF);
  assign in1 = (fr1_s_val >= -HALF) && (fr1_s_val < HALF);
  assign a0  = {~fr0_s_val[AW-1], fr0_s_val[AW-2:0]};
  assign a1  = {~fr1_s_val[AW-1], fr1_s_val[AW-2:0]};

  assign rd0_d = (rd_valid_q && in0) ? mem[rd_bank_q][a0] : '0;
  assign rd1_d = (rd_valid_q && in1) ? mem[rd_bank_q][a1] : '0;

  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    wr_angles_d = wr_angles_q;
    rd_angles_d = rd_angles_q;
    rd_bank_d   = rd_bank_q;
    rd_valid_d  = rd_valid_q;
    fr_angle_d  = fr_angle_q;
    if (restart) begin
      bank_d      = {EMPTY, EMPTY};
      wr_bank_d   = 1'b0;
      wr_cnt_d    = '0;
      wr_angles_d = '0;
      rd_angles_d = '0;
      rd_bank_d   = 1'b0;
      rd_valid_d  = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt_d = wr_cnt_q + AW'(1);
        if (wr_cnt_q == LAST) begin
          wr_cnt_d          = '0;
          bank_d[wr_bank_q] = FULL;
          wr_bank_d         = ~wr_bank_q;
          wr_angles_d       = wr_angles_q + CW'(1);
        end
      end
      // the filling bank is EMPTY, so it never collides with nb
      if (ack) begin
        if (rd_valid_q) bank_d[rd_bank_q] = EMPTY;
        bank_d[nb]  = READING;
        rd_bank_d   = nb;
        rd_valid_d  = 1'b1;
        fr_angle_d  = kAngleLength'(rd_angles_q);
        rd_angles_d = rd_angles_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank_q][wr_cnt_q] <= hf_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q      <= {EMPTY, EMPTY};
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      wr_angles_q <= '0;
      rd_angles_q <= '0;
      rd_bank_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      fr_angle_q  <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_angles_q <= wr_angles_d;
      rd_angles_q <= rd_angles_d;
      rd_bank_q   <= rd_bank_d;
      rd_valid_q  <= rd_valid_d;
      fr_angle_q  <= fr_angle_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
    end
  end

  assign fr_angle = fr_angle_q;
  assign fr0_val  = rd0_q;
  assign fr1_val  = rd1_q;

endmodule

// File: tb/tb_filtered_ram_swap_control.sv
// Directed bench for filtered_ram_swap_control with 8 samples, 3 angles.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_filtered_ram_swap_control;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              hf_valid = 1'b0;
  logic [11:0]       hf_val = '0;
  logic              hf_ready;
  logic              fr_next_angle = 1'b0;
  logic              fr_next_angle_ack;
  logic [7:0]        fr_angle;
  logic              fr_has_next_angle;
  logic signed [9:0] s0 = '0;
  logic signed [9:0] s1 = '0;
  logic signed [11:0] fr0_val;
  logic signed [11:0] fr1_val;

  int checks = 0;
  int fails  = 0;

  filtered_ram_swap_control #(
    .kAngleLength(8), .kFilteredDataLength(12), .kSLength(10),
    .kNoOfS(8), .kNoOfAngles(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .hf_valid(hf_valid), .hf_val(hf_val), .hf_ready(hf_ready),
    .fr_next_angle(fr_next_angle),
    .fr_next_angle_ack(fr_next_angle_ack),
    .fr_angle(fr_angle), .fr_has_next_angle(fr_has_next_angle),
    .fr0_s_val(s0), .fr1_s_val(s1),
    .fr0_val(fr0_val), .fr1_val(fr1_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    reset_n = 1'b0; hf_valid = 1'b0; fr_next_angle = 1'b0;
    frame_start = 1'b0; s0 = '0; s1 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_beats(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      hf_valid = 1'b1; hf_val = 12'(base + i);
      @(negedge clk);
    end
    hf_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (hf_ready !== 1'b0) begin fails++;
      $display("FAIL rst_ready got=%b exp=0", hf_ready); end
    checks++; if (fr_next_angle_ack !== 1'b0) begin fails++;
      $display("FAIL rst_ack got=%b exp=0", fr_next_angle_ack); end
    checks++; if (fr_angle !== 8'd0) begin fails++;
      $display("FAIL rst_angle got=%0d exp=0", fr_angle); end
    checks++; if (fr_has_next_angle !== 1'b1) begin fails++;
      $display("FAIL rst_has_next got=%b exp=1", fr_has_next_angle); end
    checks++; if (fr0_val !== 12'sd0 || fr1_val !== 12'sd0) begin fails++;
      $display("FAIL rst_vals got=%0d,%0d exp=0,0", fr0_val, fr1_val); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (hf_ready !== 1'b1) begin fails++;
      $display("FAIL post_rst_ready got=%b exp=1", hf_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    fr_next_angle = 1'b1;
    for (int s = 0; s < 8; s++) begin
      hf_valid = 1'b1; hf_val = 12'(10 + s);
      #1;
      checks++; if (hf_ready !== 1'b1) begin fails++;
        $display("FAIL t1_ready beat=%0d got=%b exp=1", s, hf_ready); end
      checks++; if (fr_next_angle_ack !== 1'b0) begin fails++;
        $display("FAIL t1_early_ack beat=%0d got=%b exp=0", s, fr_next_angle_ack); end
      @(negedge clk);
    end
    hf_valid = 1'b0;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t1_ack got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd0) begin fails++;
      $display("FAIL t1_angle got=%0d exp=0", fr_angle); end
    for (int s = -4; s < 4; s++) begin
      s0 = 10'(s); s1 = 10'(-s - 1);
      @(negedge clk);
      checks++; if (fr0_val !== 12'(14 + s)) begin fails++;
        $display("FAIL t1_rd0 s=%0d got=%0d exp=%0d", s, fr0_val, 14 + s); end
      checks++; if (fr1_val !== 12'(13 - s)) begin fails++;
        $display("FAIL t1_rd1 s=%0d got=%0d exp=%0d", -s - 1, fr1_val, 13 - s); end
    end
    s0 = 10'sd4; s1 = -10'sd5;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd0 || fr1_val !== 12'sd0) begin fails++;
      $display("FAIL t1_oor got=%0d,%0d exp=0,0", fr0_val, fr1_val); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      hf_valid = 1'b1; hf_val = 12'(100 + k);
      #1;
      checks++; if (hf_ready !== 1'b1) begin fails++;
        $display("FAIL t2_ready beat=%0d got=%b exp=1", k, hf_ready); end
      @(negedge clk);
    end
    hf_val = 12'd117;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (hf_ready !== 1'b0) begin fails++;
        $display("FAIL t2_full_ready got=%b exp=0", hf_ready); end
      @(negedge clk);
    end
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t2_ack0 got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (hf_ready !== 1'b0) begin fails++;
      $display("FAIL t2_reading_ready got=%b exp=0", hf_ready); end
    checks++; if (fr_angle !== 8'd0) begin fails++;
      $display("FAIL t2_angle0 got=%0d exp=0", fr_angle); end
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t2_ack1 got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd1) begin fails++;
      $display("FAIL t2_angle1 got=%0d exp=1", fr_angle); end
    for (int k = 17; k <= 24; k++) begin
      hf_valid = 1'b1; hf_val = 12'(100 + k);
      #1;
      checks++; if (hf_ready !== 1'b1) begin fails++;
        $display("FAIL t2_resume beat=%0d got=%b exp=1", k, hf_ready); end
      @(negedge clk);
    end
    hf_valid = 1'b0;
    #1;
    checks++; if (hf_ready !== 1'b0) begin fails++;
      $display("FAIL t2_frame_done_ready got=%b exp=0", hf_ready); end
    s0 = -10'sd4; s1 = 10'sd3;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd109 || fr1_val !== 12'sd116) begin fails++;
      $display("FAIL t2_rd got=%0d,%0d exp=109,116", fr0_val, fr1_val); end
  endtask

  task automatic test_frame_end();
    #1;
    checks++; if (fr_has_next_angle !== 1'b1) begin fails++;
      $display("FAIL t3_has_next_pre got=%b exp=1", fr_has_next_angle); end
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t3_ack2 got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd2) begin fails++;
      $display("FAIL t3_angle2 got=%0d exp=2", fr_angle); end
    checks++; if (fr_has_next_angle !== 1'b0) begin fails++;
      $display("FAIL t3_has_next_post got=%b exp=0", fr_has_next_angle); end
    s0 = 10'sd0; s1 = -10'sd1;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd121 || fr1_val !== 12'sd120) begin fails++;
      $display("FAIL t3_rd got=%0d,%0d exp=121,120", fr0_val, fr1_val); end
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b0) begin fails++;
      $display("FAIL t3_extra_ack got=%b exp=0", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    checks++; if (fr_has_next_angle !== 1'b1) begin fails++;
      $display("FAIL t3_restart_has_next got=%b exp=1", fr_has_next_angle); end
    checks++; if (fr_angle !== 8'd2) begin fails++;
      $display("FAIL t3_restart_angle got=%0d exp=2", fr_angle); end
    checks++; if (hf_ready !== 1'b1) begin fails++;
      $display("FAIL t3_restart_ready got=%b exp=1", hf_ready); end
    s0 = 10'sd0;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd0) begin fails++;
      $display("FAIL t3_restart_rd got=%0d exp=0", fr0_val); end
    send_beats(200, 8);
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t3_new_ack got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd0) begin fails++;
      $display("FAIL t3_new_angle got=%0d exp=0", fr_angle); end
    s0 = -10'sd4;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd200) begin fails++;
      $display("FAIL t3_new_rd got=%0d exp=200", fr0_val); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_beats(10, 8);
    send_beats(20, 7);
    hf_valid = 1'b1; hf_val = 12'd27; fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1 || hf_ready !== 1'b1) begin fails++;
      $display("FAIL t4_same_edge got=%b,%b exp=1,1", fr_next_angle_ack, hf_ready); end
    @(negedge clk);
    hf_valid = 1'b0;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t4_next_ack got=%b exp=1", fr_next_angle_ack); end
    checks++; if (fr_angle !== 8'd0) begin fails++;
      $display("FAIL t4_angle0 got=%0d exp=0", fr_angle); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd1) begin fails++;
      $display("FAIL t4_angle1 got=%0d exp=1", fr_angle); end
    checks++; if (hf_ready !== 1'b1) begin fails++;
      $display("FAIL t4_ready got=%b exp=1", hf_ready); end
    s0 = -10'sd4; s1 = 10'sd3;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd20 || fr1_val !== 12'sd27) begin fails++;
      $display("FAIL t4_rd got=%0d,%0d exp=20,27", fr0_val, fr1_val); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_beats(40, 8);
    fr_next_angle = 1'b1;
    @(negedge clk);
    fr_next_angle = 1'b0;
    s0 = 10'sd1;
    send_beats(50, 4);
    #1;
    checks++; if (fr0_val !== 12'sd45) begin fails++;
      $display("FAIL t5_pre_rd got=%0d exp=45", fr0_val); end
    hf_valid = 1'b1; hf_val = 12'd54;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (fr0_val !== 12'sd0) begin fails++;
      $display("FAIL t5_async_rd got=%0d exp=0", fr0_val); end
    checks++; if (hf_ready !== 1'b0) begin fails++;
      $display("FAIL t5_async_ready got=%b exp=0", hf_ready); end
    checks++; if (fr_has_next_angle !== 1'b1 || fr_angle !== 8'd0) begin fails++;
      $display("FAIL t5_async_state got=%b,%0d exp=1,0", fr_has_next_angle, fr_angle); end
    hf_valid = 1'b0; s0 = '0;
    @(negedge clk);
    reset_n = 1'b1;
    send_beats(60, 8);
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t5_ack got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd0) begin fails++;
      $display("FAIL t5_angle got=%0d exp=0", fr_angle); end
    s0 = -10'sd4; s1 = 10'sd3;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd60 || fr1_val !== 12'sd67) begin fails++;
      $display("FAIL t5_rd got=%0d,%0d exp=60,67", fr0_val, fr1_val); end
  endtask

  task automatic test_frame_start_ignored();
    do_reset();
    send_beats(70, 8);
    fr_next_angle = 1'b1;
    @(negedge clk);
    fr_next_angle = 1'b0;
    send_beats(80, 3);
    frame_start = 1'b1; hf_valid = 1'b1; hf_val = 12'd83;
    #1;
    checks++; if (hf_ready !== 1'b1) begin fails++;
      $display("FAIL t6_ready got=%b exp=1", hf_ready); end
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd0 || fr_has_next_angle !== 1'b1) begin fails++;
      $display("FAIL t6_state got=%0d,%b exp=0,1", fr_angle, fr_has_next_angle); end
    send_beats(84, 4);
    fr_next_angle = 1'b1;
    #1;
    checks++; if (fr_next_angle_ack !== 1'b1) begin fails++;
      $display("FAIL t6_ack got=%b exp=1", fr_next_angle_ack); end
    @(negedge clk);
    fr_next_angle = 1'b0;
    #1;
    checks++; if (fr_angle !== 8'd1) begin fails++;
      $display("FAIL t6_angle got=%0d exp=1", fr_angle); end
    s0 = -10'sd4; s1 = 10'sd3;
    @(negedge clk);
    checks++; if (fr0_val !== 12'sd80 || fr1_val !== 12'sd87) begin fails++;
      $display("FAIL t6_rd got=%0d,%0d exp=80,87", fr0_val, fr1_val); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame_end();
    test_back_to_back();
    test_async_reset();
    test_frame_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
